// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: state encoding, default pass code and width helper shared by
// the run_monitor interface, channel and top.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_PASS_CODE = 32'd1;

    // A single core still needs a one-bit fail index
    function automatic int failIdxW(input int nCores);
        return (nCores > 1) ? $clog2(nCores) : 1;
    endfunction

endpackage

// File: rtl/run_monitor_if.sv
// run_monitor_if: run-control and completion signals between a test harness
// (master) and the run_monitor block (slave).
interface run_monitor_if
    import run_monitor_pkg::*;
#(
    parameter int N_CORES = 1,
    parameter int XLEN    = 32,
    parameter int CYCLE_W = 32
);
    localparam int FAIL_W = failIdxW(N_CORES);

    logic                       start;
    logic [N_CORES-1:0]         trap;
    logic [N_CORES-1:0]         retire;
    logic [N_CORES*XLEN-1:0]    result;

    logic [N_CORES-1:0]         core_resetn;
    logic                       busy;
    logic                       done;
    logic                       pass;
    logic                       timed_out;
    logic [N_CORES-1:0]         trapped;
    logic [CYCLE_W-1:0]         cycles;
    logic [FAIL_W-1:0]          fail_core;
    logic [XLEN-1:0]            fail_code;
    logic [N_CORES*CYCLE_W-1:0] retired;

    modport master (
        output start, trap, retire, result,
        input  core_resetn, busy, done, pass, timed_out, trapped, cycles,
               fail_core, fail_code, retired
    );

    modport slave (
        input  start, trap, retire, result,
        output core_resetn, busy, done, pass, timed_out, trapped, cycles,
               fail_core, fail_code, retired
    );

endinterface

// File: rtl/run_monitor_chan.sv
// run_monitor_chan: per-core trap edge detect, sticky trapped flag, result-code
// capture and (with RUN_MONITOR_RETIRE_CNT_EN) a saturating retire counter.
module run_monitor_chan #(
    parameter int XLEN    = 32,
    parameter int CYCLE_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               run_i,
    input  logic               trap_i,
    input  logic               retire_i,
    input  logic [XLEN-1:0]    result_i,
    output logic               trapped_o,
    output logic               trappedNext_o,
    output logic [XLEN-1:0]    codeNext_o,
    output logic [CYCLE_W-1:0] retired_o
);
    logic            trapped_q, trapped_d;
    logic [XLEN-1:0] code_q, code_d;
    logic            trapEdge;

    // A level-high trap only counts once: the first RUN cycle it is seen
    assign trapEdge = run_i && trap_i && !trapped_q;

    always_comb begin
        trapped_d = trapped_q;
        code_d    = code_q;
        if (clear_i) begin
            trapped_d = 1'b0;
            code_d    = '0;
        end else if (trapEdge) begin
            trapped_d = 1'b1;
            code_d    = result_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trapped_q <= 1'b0;
            code_q    <= '0;
        end else begin
            trapped_q <= trapped_d;
            code_q    <= code_d;
        end
    end

    assign trapped_o     = trapped_q;
    assign trappedNext_o = trapped_d;
    assign codeNext_o    = code_d;

`ifdef RUN_MONITOR_RETIRE_CNT_EN
    logic [CYCLE_W-1:0] retireCnt_q, retireCnt_d;

    always_comb begin
        retireCnt_d = retireCnt_q;
        if (clear_i) begin
            retireCnt_d = '0;
        end else if (run_i && retire_i && !trapped_q && (retireCnt_q != '1)) begin
            retireCnt_d = retireCnt_q + CYCLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retireCnt_q <= '0;
        end else begin
            retireCnt_q <= retireCnt_d;
        end
    end

    assign retired_o = retireCnt_q;
`else
    logic unusedRetire;
    assign unusedRetire = retire_i;
    assign retired_o    = '0;
`endif

endmodule

// File: rtl/run_monitor.sv
// run_monitor: holds cores in reset until started, times the run, and reports
// pass/fail with the first failing core. Optional retire counters: RUN_MONITOR_RETIRE_CNT_EN.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int                 N_CORES   = 1,
    parameter int                 XLEN      = 32,
    parameter int                 CYCLE_W   = 32,
    parameter logic [CYCLE_W-1:0] TIMEOUT   = CYCLE_W'(400),
    parameter logic [XLEN-1:0]    PASS_CODE = XLEN'(DEFAULT_PASS_CODE)
) (
    input  logic         clk,
    input  logic         reset,
    run_monitor_if.slave bus
);
    localparam int                 FAIL_W       = failIdxW(N_CORES);
    localparam logic [CYCLE_W-1:0] TIMEOUT_LAST = TIMEOUT - CYCLE_W'(1);

    state_e             state_q, state_d;
    logic               inRun, clear, allTrapped, timeoutHit, endRun;
    logic               busy, done;
    logic [CYCLE_W-1:0] cycles_q, cycles_d;
    logic               pass_q, pass_d, timedOut_q, timedOut_d;
    logic [FAIL_W-1:0]  failCore_q, failCore_d, failIdx;
    logic [XLEN-1:0]    failCode_q, failCode_d, failCodeSel;
    logic               anyFail;

    wire [N_CORES-1:0]         trappedW;
    wire [N_CORES-1:0]         trappedNextW;
    wire [N_CORES*XLEN-1:0]    codeNextW;
    wire [N_CORES*CYCLE_W-1:0] retiredW;

    assign inRun      = (state_q == RUN);
    assign clear      = !inRun && bus.start;
    assign allTrapped = &trappedNextW;
    assign timeoutHit = (cycles_q == TIMEOUT_LAST);

    for (genvar i = 0; i < N_CORES; i++) begin : gChan
        run_monitor_chan #(
            .XLEN    (XLEN),
            .CYCLE_W (CYCLE_W)
        ) uChan (
            .clk           (clk),
            .reset         (reset),
            .clear_i       (clear),
            .run_i         (inRun),
            .trap_i        (bus.trap[i]),
            .retire_i      (bus.retire[i]),
            .result_i      (bus.result[i*XLEN +: XLEN]),
            .trapped_o     (trappedW[i]),
            .trappedNext_o (trappedNextW[i]),
            .codeNext_o    (codeNextW[i*XLEN +: XLEN]),
            .retired_o     (retiredW[i*CYCLE_W +: CYCLE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (bus.start) state_d = RUN;
            RUN:        if (allTrapped || timeoutHit) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign endRun = inRun && (state_d == DONE);

    // Scan from the top so the lowest failing index is the one left standing
    always_comb begin
        anyFail     = 1'b0;
        failIdx     = '0;
        failCodeSel = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (!trappedNextW[i] || (codeNextW[i*XLEN +: XLEN] != PASS_CODE)) begin
                anyFail     = 1'b1;
                failIdx     = FAIL_W'(i);
                failCodeSel = trappedNextW[i] ? codeNextW[i*XLEN +: XLEN] : '0;
            end
        end
    end

    always_comb begin
        cycles_d   = cycles_q;
        pass_d     = pass_q;
        timedOut_d = timedOut_q;
        failCore_d = failCore_q;
        failCode_d = failCode_q;
        if (clear) begin
            cycles_d   = '0;
            pass_d     = 1'b0;
            timedOut_d = 1'b0;
            failCore_d = '0;
            failCode_d = '0;
        end else begin
            if (inRun && (cycles_q != '1)) begin
                cycles_d = cycles_q + CYCLE_W'(1);
            end
            if (endRun) begin
                pass_d     = !anyFail;
                timedOut_d = !allTrapped;
                failCore_d = failIdx;
                failCode_d = failCodeSel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycles_q   <= '0;
            pass_q     <= 1'b0;
            timedOut_q <= 1'b0;
            failCore_q <= '0;
            failCode_q <= '0;
        end else begin
            cycles_q   <= cycles_d;
            pass_q     <= pass_d;
            timedOut_q <= timedOut_d;
            failCore_q <= failCore_d;
            failCode_q <= failCode_d;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.core_resetn = {N_CORES{busy}};
    assign bus.pass        = pass_q;
    assign bus.timed_out   = timedOut_q;
    assign bus.trapped     = trappedW;
    assign bus.cycles      = cycles_q;
    assign bus.fail_core   = failCore_q;
    assign bus.fail_code   = failCode_q;
    assign bus.retired     = retiredW;

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: directed checks of run_monitor with a single-core (TIMEOUT=400)
// and a dual-core (TIMEOUT=20) instance; retire expectations follow RUN_MONITOR_RETIRE_CNT_EN.
module tb_run_monitor;

`ifdef RUN_MONITOR_RETIRE_CNT_EN
    localparam bit RETIRE_EN = 1'b1;
`else
    localparam bit RETIRE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst1;
    logic rst2;
    int   assertCount = 0;
    int   failCount   = 0;

    always #5 clk = ~clk;

    run_monitor_if #(.N_CORES(1), .XLEN(32), .CYCLE_W(32)) bus1 ();
    run_monitor_if #(.N_CORES(2), .XLEN(32), .CYCLE_W(32)) bus2 ();

    run_monitor #(
        .N_CORES(1), .XLEN(32), .CYCLE_W(32), .TIMEOUT(400), .PASS_CODE(1)
    ) dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (bus1)
    );

    run_monitor #(
        .N_CORES(2), .XLEN(32), .CYCLE_W(32), .TIMEOUT(20), .PASS_CODE(1)
    ) dut2 (
        .clk   (clk),
        .reset (rst2),
        .bus   (bus2)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input int which, input logic st, input logic [1:0] tr,
                                 input logic [63:0] res, input logic [1:0] ret);
        if (which == 1) begin
            bus1.start  = st;
            bus1.trap   = tr[0];
            bus1.result = res[31:0];
            bus1.retire = ret[0];
        end else begin
            bus2.start  = st;
            bus2.trap   = tr;
            bus2.result = res;
            bus2.retire = ret;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        applyStimulus(1, 1'b0, 2'b00, 64'd0, 2'b00);
        applyStimulus(2, 1'b0, 2'b00, 64'd0, 2'b00);
        tick(2);
        checkOutput("rst1_busy",    64'(bus1.busy),        64'd0);
        checkOutput("rst1_done",    64'(bus1.done),        64'd0);
        checkOutput("rst1_resetn",  64'(bus1.core_resetn), 64'd0);
        checkOutput("rst1_cycles",  64'(bus1.cycles),      64'd0);
        checkOutput("rst1_pass",    64'(bus1.pass),        64'd0);
        checkOutput("rst2_resetn",  64'(bus2.core_resetn), 64'd0);
        checkOutput("rst2_retired", 64'(bus2.retired),     64'd0);
        rst1 = 1'b0;
        rst2 = 1'b0;
        tick(1);
        checkOutput("idle1_busy", 64'(bus1.busy), 64'd0);

        $display("[TB] single core: trap at run cycle 10 with pass code");
        applyStimulus(1, 1'b1, 2'b00, 64'd0, 2'b00);
        tick(1);
        checkOutput("a_busy",   64'(bus1.busy),        64'd1);
        checkOutput("a_resetn", 64'(bus1.core_resetn), 64'd1);
        checkOutput("a_cyc0",   64'(bus1.cycles),      64'd0);
        applyStimulus(1, 1'b0, 2'b00, 64'd0, 2'b00);
        tick(1);
        checkOutput("a_cyc1", 64'(bus1.cycles), 64'd1);
        tick(3);
        applyStimulus(1, 1'b1, 2'b00, 64'd0, 2'b00);
        tick(1);
        checkOutput("a_start_ignored_busy", 64'(bus1.busy),   64'd1);
        checkOutput("a_start_ignored_cyc",  64'(bus1.cycles), 64'd5);
        applyStimulus(1, 1'b0, 2'b00, 64'd0, 2'b00);
        tick(5);
        checkOutput("a_cyc10", 64'(bus1.cycles), 64'd10);
        applyStimulus(1, 1'b0, 2'b01, 64'd1, 2'b00);
        tick(1);
        checkOutput("a_done",      64'(bus1.done),        64'd1);
        checkOutput("a_busy_low",  64'(bus1.busy),        64'd0);
        checkOutput("a_resetn_lo", 64'(bus1.core_resetn), 64'd0);
        checkOutput("a_pass",      64'(bus1.pass),        64'd1);
        checkOutput("a_timedout",  64'(bus1.timed_out),   64'd0);
        checkOutput("a_cycles",    64'(bus1.cycles),      64'd11);
        checkOutput("a_trapped",   64'(bus1.trapped),     64'd1);
        checkOutput("a_failcode",  64'(bus1.fail_code),   64'd0);
        applyStimulus(1, 1'b0, 2'b00, 64'd1, 2'b00);
        tick(2);
        checkOutput("a_frozen_cyc",  64'(bus1.cycles), 64'd11);
        checkOutput("a_frozen_done", 64'(bus1.done),   64'd1);

        $display("[TB] single core: trap held from first run cycle, then restart");
        applyStimulus(1, 1'b1, 2'b01, 64'd1, 2'b00);
        tick(1);
        checkOutput("d_busy",    64'(bus1.busy),    64'd1);
        checkOutput("d_cyc0",    64'(bus1.cycles),  64'd0);
        checkOutput("d_cleared", 64'(bus1.trapped), 64'd0);
        checkOutput("d_pass_clr",64'(bus1.pass),    64'd0);
        applyStimulus(1, 1'b0, 2'b01, 64'd1, 2'b00);
        tick(1);
        checkOutput("d_done",    64'(bus1.done),    64'd1);
        checkOutput("d_cycles",  64'(bus1.cycles),  64'd1);
        checkOutput("d_pass",    64'(bus1.pass),    64'd1);
        checkOutput("d_trapped", 64'(bus1.trapped), 64'd1);
        applyStimulus(1, 1'b1, 2'b00, 64'd2, 2'b00);
        tick(1);
        checkOutput("d2_busy",    64'(bus1.busy),    64'd1);
        checkOutput("d2_trapped", 64'(bus1.trapped), 64'd0);
        checkOutput("d2_cyc0",    64'(bus1.cycles),  64'd0);
        applyStimulus(1, 1'b0, 2'b01, 64'd2, 2'b00);
        tick(1);
        checkOutput("d2_done",     64'(bus1.done),      64'd1);
        checkOutput("d2_pass",     64'(bus1.pass),      64'd0);
        checkOutput("d2_failcore", 64'(bus1.fail_core), 64'd0);
        checkOutput("d2_failcode", 64'(bus1.fail_code), 64'd2);
        checkOutput("d2_timedout", 64'(bus1.timed_out), 64'd0);

        $display("[TB] single core: reset asserted mid-run");
        applyStimulus(1, 1'b1, 2'b00, 64'd0, 2'b00);
        tick(1);
        applyStimulus(1, 1'b0, 2'b00, 64'd0, 2'b00);
        tick(6);
        checkOutput("r_cyc6", 64'(bus1.cycles), 64'd6);
        rst1 = 1'b1;
        tick(1);
        checkOutput("r_busy",   64'(bus1.busy),        64'd0);
        checkOutput("r_resetn", 64'(bus1.core_resetn), 64'd0);
        checkOutput("r_cycles", 64'(bus1.cycles),      64'd0);
        checkOutput("r_done",   64'(bus1.done),        64'd0);
        rst1 = 1'b0;
        tick(1);
        checkOutput("r_idle_busy", 64'(bus1.busy), 64'd0);

        $display("[TB] single core: retire pulses before and after trap");
        applyStimulus(1, 1'b1, 2'b00, 64'd0, 2'b00);
        tick(1);
        applyStimulus(1, 1'b0, 2'b00, 64'd0, 2'b01);
        tick(7);
        applyStimulus(1, 1'b0, 2'b01, 64'd1, 2'b00);
        tick(1);
        checkOutput("e_done",    64'(bus1.done),    64'd1);
        checkOutput("e_retired", 64'(bus1.retired), RETIRE_EN ? 64'd7 : 64'd0);
        applyStimulus(1, 1'b0, 2'b01, 64'd1, 2'b01);
        tick(2);
        checkOutput("e_retired_hold", 64'(bus1.retired), RETIRE_EN ? 64'd7 : 64'd0);
        applyStimulus(1, 1'b0, 2'b00, 64'd0, 2'b00);

        $display("[TB] dual core: core1 fails with code 5, core0 passes later");
        applyStimulus(2, 1'b1, 2'b00, 64'd0, 2'b00);
        tick(1);
        checkOutput("b_busy",   64'(bus2.busy),        64'd1);
        checkOutput("b_resetn", 64'(bus2.core_resetn), 64'd3);
        applyStimulus(2, 1'b0, 2'b00, 64'd0, 2'b00);
        tick(4);
        applyStimulus(2, 1'b0, 2'b10, {32'd5, 32'd0}, 2'b00);
        tick(1);
        checkOutput("b_trapped1", 64'(bus2.trapped), 64'd2);
        checkOutput("b_running",  64'(bus2.busy),    64'd1);
        applyStimulus(2, 1'b0, 2'b10, {32'd7, 32'd0}, 2'b11);
        tick(3);
        applyStimulus(2, 1'b0, 2'b11, {32'd7, 32'd1}, 2'b11);
        tick(1);
        checkOutput("b_done",     64'(bus2.done),      64'd1);
        checkOutput("b_cycles",   64'(bus2.cycles),    64'd9);
        checkOutput("b_pass",     64'(bus2.pass),      64'd0);
        checkOutput("b_failcore", 64'(bus2.fail_core), 64'd1);
        checkOutput("b_failcode", 64'(bus2.fail_code), 64'd5);
        checkOutput("b_timedout", 64'(bus2.timed_out), 64'd0);
        checkOutput("b_trapped",  64'(bus2.trapped),   64'd3);
        checkOutput("b_retired",  64'(bus2.retired),
                    RETIRE_EN ? {32'd0, 32'd4} : 64'd0);

        $display("[TB] dual core: timeout with core0 never trapping");
        applyStimulus(2, 1'b1, 2'b00, 64'd0, 2'b00);
        tick(1);
        applyStimulus(2, 1'b0, 2'b00, 64'd0, 2'b00);
        tick(19);
        checkOutput("c_cyc19", 64'(bus2.cycles), 64'd19);
        checkOutput("c_busy",  64'(bus2.busy),   64'd1);
        checkOutput("c_ndone", 64'(bus2.done),   64'd0);
        applyStimulus(2, 1'b0, 2'b10, {32'd1, 32'd0}, 2'b00);
        tick(1);
        checkOutput("c_done",     64'(bus2.done),      64'd1);
        checkOutput("c_cycles",   64'(bus2.cycles),    64'd20);
        checkOutput("c_timedout", 64'(bus2.timed_out), 64'd1);
        checkOutput("c_pass",     64'(bus2.pass),      64'd0);
        checkOutput("c_failcore", 64'(bus2.fail_core), 64'd0);
        checkOutput("c_failcode", 64'(bus2.fail_code), 64'd0);
        checkOutput("c_trapped",  64'(bus2.trapped),   64'd2);
        applyStimulus(2, 1'b0, 2'b11, {32'd1, 32'd1}, 2'b00);
        tick(2);
        checkOutput("c_late_trapped", 64'(bus2.trapped), 64'd2);
        checkOutput("c_late_cycles",  64'(bus2.cycles),  64'd20);
        checkOutput("c_late_done",    64'(bus2.done),    64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
